// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder
// Receive-side monitor for a 3-digit multiplexed seven-segment bus. It samples
// each digit once its enable and segment lines have settled, decodes the pattern
// back to hex and publishes the 3-digit frame after MATCH_FRAMES identical frames.
// Optional feature macro: SCAN_DP_CAPTURE_EN. When it is defined, the decimal
// point is kept with each digit, takes part in the frame compare and is published
// on o_dp. When it is not defined, o_dp is tied to zero.
module sevenseg_scan_decoder #(
  parameter int SETTLE_CYC   = 16,
  parameter int MATCH_FRAMES = 3,
  parameter int TIMEOUT_CYC  = 500_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_digit_en,
  input  logic [7:0]  i_seven_seg,
  output logic [11:0] o_digits,
  output logic        o_frame_valid,
  output logic        o_frame_stb,
  output logic        o_seg_err,
  output logic        o_timeout,
  output logic [2:0]  o_dp
);

`ifdef SCAN_DP_CAPTURE_EN
  localparam int SW = 5;   // per-slot width: {dp, hex}
`else
  localparam int SW = 4;   // per-slot width: hex only
`endif
  localparam int          SCW      = $clog2(SETTLE_CYC + 1);
  localparam logic [SCW-1:0] SETTLE_N = SCW'(SETTLE_CYC);
  localparam logic [3:0]  MATCH_N  = 4'(MATCH_FRAMES);
  localparam logic [19:0] TO_N     = 20'(TIMEOUT_CYC);
  localparam logic [19:0] TO_M1    = 20'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       en_lat_q, en_lat_d;
  logic [7:0]       seg_lat_q, seg_lat_d;
  logic [SCW-1:0]   settle_q, settle_d;

  logic [3*SW-1:0]  frame_q, frame_d;     // slots under assembly
  logic [2:0]       mask_q, mask_d;       // slots captured so far
  logic [3*SW-1:0]  prev_q, prev_d;       // last complete frame
  logic [3:0]       match_q, match_d;
  logic [11:0]      digits_q, digits_d;
  logic             valid_q, valid_d;
  logic             stb_q, stb_d;
  logic             err_q, err_d;
  logic             tout_q, tout_d;
  logic [19:0]      tcnt_q, tcnt_d;
`ifdef SCAN_DP_CAPTURE_EN
  logic [2:0]       dp_q, dp_d;
`endif

  logic             dec_valid;
  logic [3:0]       dec_code;
  logic [SW-1:0]    wr_val;
  logic [3*SW-1:0]  pub_frame;            // published frame in slot layout

  function automatic logic is_onehot3(input logic [2:0] e);
    return (e == 3'b001) || (e == 3'b010) || (e == 3'b100);
  endfunction

  // Segment pattern {g..a} back to a hex code; unknown patterns flag invalid
  always_comb begin
    dec_valid = 1'b1;
    dec_code  = 4'h0;
    case (seg_lat_q[6:0])
      7'h3F: dec_code = 4'h0;
      7'h06: dec_code = 4'h1;
      7'h5B: dec_code = 4'h2;
      7'h4F: dec_code = 4'h3;
      7'h66: dec_code = 4'h4;
      7'h6D: dec_code = 4'h5;
      7'h7D: dec_code = 4'h6;
      7'h07: dec_code = 4'h7;
      7'h7F: dec_code = 4'h8;
      7'h6F: dec_code = 4'h9;
      7'h77: dec_code = 4'hA;
      7'h7C: dec_code = 4'hB;
      7'h39: dec_code = 4'hC;
      7'h5E: dec_code = 4'hD;
      7'h79: dec_code = 4'hE;
      7'h71: dec_code = 4'hF;
      default: dec_valid = 1'b0;
    endcase
  end

`ifdef SCAN_DP_CAPTURE_EN
  assign wr_val = {seg_lat_q[7], dec_code};
`else
  assign wr_val = dec_code;
`endif

  // Rebuild the published frame in slot layout so it compares directly
  for (genvar gi = 0; gi < 3; gi++) begin : g_pub
`ifdef SCAN_DP_CAPTURE_EN
    assign pub_frame[gi*SW +: SW] = {dp_q[gi], digits_q[gi*4 +: 4]};
`else
    assign pub_frame[gi*SW +: SW] = digits_q[gi*4 +: 4];
`endif
  end

  // Scan FSM: wait for one-hot enable, settle, take one sample, hold
  always_comb begin
    state_d   = state_q;
    en_lat_d  = en_lat_q;
    seg_lat_d = seg_lat_q;
    settle_d  = settle_q;
    case (state_q)
      ST_IDLE: begin
        if (is_onehot3(i_digit_en)) begin
          en_lat_d  = i_digit_en;
          seg_lat_d = i_seven_seg;
          settle_d  = SCW'(1);
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!is_onehot3(i_digit_en)) begin
          state_d = ST_IDLE;
        end else if ((i_digit_en != en_lat_q) || (i_seven_seg != seg_lat_q)) begin
          en_lat_d  = i_digit_en;
          seg_lat_d = i_seven_seg;
          settle_d  = SCW'(1);
        end else if (settle_q >= SETTLE_N) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_SAMPLE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (i_digit_en != en_lat_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame assembly, match counting, publishing and timeout supervision
  always_comb begin
    logic [3*SW-1:0] frame_new;
    logic [2:0]      mask_w;
    logic [3:0]      match_n;
    frame_d   = frame_q;
    mask_d    = mask_q;
    prev_d    = prev_q;
    match_d   = match_q;
    digits_d  = digits_q;
    valid_d   = valid_q;
    stb_d     = 1'b0;
    err_d     = err_q;
    tout_d    = tout_q;
    tcnt_d    = tcnt_q;
`ifdef SCAN_DP_CAPTURE_EN
    dp_d      = dp_q;
`endif
    frame_new = frame_q;
    mask_w    = mask_q | en_lat_q;
    match_n   = match_q;
    if (state_q == ST_SAMPLE) begin
      tcnt_d = 20'd0;
      tout_d = 1'b0;
      if (dec_valid) begin
        for (int i = 0; i < 3; i++) begin
          if (en_lat_q[i]) frame_new[i*SW +: SW] = wr_val;
        end
        frame_d = frame_new;
        if (mask_w == 3'b111) begin
          mask_d = 3'b000;
          if (frame_new == prev_q)
            match_n = (match_q >= MATCH_N) ? MATCH_N : match_q + 4'd1;
          else
            match_n = 4'd1;
          match_d = match_n;
          prev_d  = frame_new;
          if ((match_n == MATCH_N) && ((frame_new != pub_frame) || !valid_q)) begin
            for (int i = 0; i < 3; i++) begin
              digits_d[i*4 +: 4] = frame_new[i*SW +: 4];
`ifdef SCAN_DP_CAPTURE_EN
              dp_d[i] = frame_new[i*SW + 4];
`endif
            end
            valid_d = 1'b1;
            stb_d   = 1'b1;
          end
        end else begin
          mask_d = mask_w;
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (tcnt_q < TO_N) begin
      tcnt_d = tcnt_q + 20'd1;
      if (tcnt_q == TO_M1) begin
        tout_d  = 1'b1;
        valid_d = 1'b0;
        mask_d  = 3'b000;
        match_d = 4'd0;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      en_lat_q  <= 3'b000;
      seg_lat_q <= 8'h00;
      settle_q  <= '0;
      frame_q   <= '0;
      mask_q    <= 3'b000;
      prev_q    <= '0;
      match_q   <= 4'd0;
      digits_q  <= 12'h000;
      valid_q   <= 1'b0;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
      tout_q    <= 1'b0;
      tcnt_q    <= 20'd0;
`ifdef SCAN_DP_CAPTURE_EN
      dp_q      <= 3'b000;
`endif
    end else begin
      state_q   <= state_d;
      en_lat_q  <= en_lat_d;
      seg_lat_q <= seg_lat_d;
      settle_q  <= settle_d;
      frame_q   <= frame_d;
      mask_q    <= mask_d;
      prev_q    <= prev_d;
      match_q   <= match_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
      tout_q    <= tout_d;
      tcnt_q    <= tcnt_d;
`ifdef SCAN_DP_CAPTURE_EN
      dp_q      <= dp_d;
`endif
    end
  end

  assign o_digits      = digits_q;
  assign o_frame_valid = valid_q;
  assign o_frame_stb   = stb_q;
  assign o_seg_err     = err_q;
  assign o_timeout     = tout_q;
`ifdef SCAN_DP_CAPTURE_EN
  assign o_dp          = dp_q;
`else
  assign o_dp          = 3'b000;
`endif

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder: scan frames, glitches, bad
// patterns, frame changes, timeout, mid-scan reset and decimal-point handling.
`timescale 1ns/1ps
module tb_sevenseg_scan_decoder;
  localparam int DW = 40;     // cycles each digit is driven
  localparam int TO = 1000;   // shortened timeout for simulation

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [2:0]  i_digit_en;
  logic [7:0]  i_seven_seg;
  logic [11:0] o_digits;
  logic        o_frame_valid;
  logic        o_frame_stb;
  logic        o_seg_err;
  logic        o_timeout;
  logic [2:0]  o_dp;

  int n_cmp = 0;
  int n_bad = 0;
  int stb_cnt = 0;

  sevenseg_scan_decoder #(
    .SETTLE_CYC(16), .MATCH_FRAMES(3), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_digit_en(i_digit_en),
    .i_seven_seg(i_seven_seg), .o_digits(o_digits),
    .o_frame_valid(o_frame_valid), .o_frame_stb(o_frame_stb),
    .o_seg_err(o_seg_err), .o_timeout(o_timeout), .o_dp(o_dp)
  );

  always #5 i_clk = ~i_clk;

  // Count every cycle the strobe is high, so a stretched pulse shows up
  always @(negedge i_clk) begin
    if (o_frame_stb) stb_cnt <= stb_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] en, input logic [7:0] seg, input int n);
    i_digit_en  = en;
    i_seven_seg = seg;
    step(n);
  endtask

  task automatic scan_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
    drive(3'b001, s0, DW);
    drive(3'b010, s1, DW);
    drive(3'b100, s2, DW);
    $display("frame d0=%h d1=%h d2=%h -> digits=%h valid=%b err=%b tout=%b dp=%b stbs=%0d",
             s0, s1, s2, o_digits, o_frame_valid, o_seg_err, o_timeout, o_dp, stb_cnt);
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_digit_en = 3'b000; i_seven_seg = 8'h00;
    step(3);
    n_cmp++; if (o_digits !== 12'h000) begin n_bad++; $display("FAIL reset_digits got %h want 000", o_digits); end
    n_cmp++; if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", o_frame_valid); end
    n_cmp++; if (o_frame_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb got %b want 0", o_frame_stb); end
    n_cmp++; if (o_seg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", o_seg_err); end
    n_cmp++; if (o_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_tout got %b want 0", o_timeout); end
    n_cmp++; if (o_dp !== 3'b000) begin n_bad++; $display("FAIL reset_dp got %b want 000", o_dp); end
    i_rst = 1'b0;
    step(1);
  endtask

  task automatic test_basic;
    int base;
    base = stb_cnt;
    scan_frame(8'h06, 8'h5B, 8'h39);
    scan_frame(8'h06, 8'h5B, 8'h39);
    n_cmp++; if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_f2 got %b want 0", o_frame_valid); end
    n_cmp++; if (stb_cnt !== base) begin n_bad++; $display("FAIL basic_stb_f2 got %0d want %0d", stb_cnt, base); end
    scan_frame(8'h06, 8'h5B, 8'h39);
    n_cmp++; if (o_digits !== 12'hC21) begin n_bad++; $display("FAIL basic_digits got %h want C21", o_digits); end
    n_cmp++; if (o_frame_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", o_frame_valid); end
    n_cmp++; if (stb_cnt !== base + 1) begin n_bad++; $display("FAIL basic_stb got %0d want %0d", stb_cnt, base + 1); end
    n_cmp++; if (o_seg_err !== 1'b0) begin n_bad++; $display("FAIL basic_err got %b want 0", o_seg_err); end
  endtask

  task automatic test_glitch;
    int base;
    base = stb_cnt;
    for (int f = 0; f < 3; f++) begin
      drive(3'b001, 8'h06, DW);
      drive(3'b010, 8'h5B, 8);
      drive(3'b010, 8'h7F, 5);
      drive(3'b010, 8'h5B, DW);
      drive(3'b100, 8'h39, DW);
      $display("glitch frame %0d -> digits=%h err=%b stbs=%0d", f, o_digits, o_seg_err, stb_cnt);
    end
    n_cmp++; if (o_digits !== 12'hC21) begin n_bad++; $display("FAIL glitch_digits got %h want C21", o_digits); end
    n_cmp++; if (stb_cnt !== base) begin n_bad++; $display("FAIL glitch_stb got %0d want %0d", stb_cnt, base); end
    n_cmp++; if (o_seg_err !== 1'b0) begin n_bad++; $display("FAIL glitch_err got %b want 0", o_seg_err); end
  endtask

  task automatic test_seg_err;
    int base;
    base = stb_cnt;
    scan_frame(8'h49, 8'h5B, 8'h39);
    n_cmp++; if (o_seg_err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", o_seg_err); end
    n_cmp++; if (o_digits !== 12'hC21) begin n_bad++; $display("FAIL err_digits got %h want C21", o_digits); end
    scan_frame(8'h06, 8'h5B, 8'h39);
    scan_frame(8'h06, 8'h5B, 8'h39);
    n_cmp++; if (o_seg_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", o_seg_err); end
    n_cmp++; if (stb_cnt !== base) begin n_bad++; $display("FAIL err_stb got %0d want %0d", stb_cnt, base); end
  endtask

  task automatic test_change_back;
    int base;
    base = stb_cnt;
    scan_frame(8'h4F, 8'h5B, 8'h39);
    scan_frame(8'h4F, 8'h5B, 8'h39);
    n_cmp++; if (o_frame_valid !== 1'b1) begin n_bad++; $display("FAIL chg_valid got %b want 1", o_frame_valid); end
    for (int f = 0; f < 3; f++) scan_frame(8'h06, 8'h5B, 8'h39);
    n_cmp++; if (o_digits !== 12'hC21) begin n_bad++; $display("FAIL chg_digits got %h want C21", o_digits); end
    n_cmp++; if (stb_cnt !== base) begin n_bad++; $display("FAIL chg_stb got %0d want %0d", stb_cnt, base); end
    for (int f = 0; f < 3; f++) scan_frame(8'h4F, 8'h5B, 8'h39);
    n_cmp++; if (o_digits !== 12'hC23) begin n_bad++; $display("FAIL chg_new_digits got %h want C23", o_digits); end
    n_cmp++; if (stb_cnt !== base + 1) begin n_bad++; $display("FAIL chg_new_stb got %0d want %0d", stb_cnt, base + 1); end
  endtask

  task automatic test_timeout;
    int base;
    drive(3'b000, 8'h00, 900);
    n_cmp++; if (o_timeout !== 1'b0) begin n_bad++; $display("FAIL tout_early got %b want 0", o_timeout); end
    n_cmp++; if (o_frame_valid !== 1'b1) begin n_bad++; $display("FAIL tout_early_valid got %b want 1", o_frame_valid); end
    drive(3'b000, 8'h00, 110);
    $display("idle 1010 cycles -> tout=%b valid=%b", o_timeout, o_frame_valid);
    n_cmp++; if (o_timeout !== 1'b1) begin n_bad++; $display("FAIL tout_set got %b want 1", o_timeout); end
    n_cmp++; if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL tout_valid got %b want 0", o_frame_valid); end
    base = stb_cnt;
    scan_frame(8'h4F, 8'h5B, 8'h39);
    n_cmp++; if (o_timeout !== 1'b0) begin n_bad++; $display("FAIL tout_clear got %b want 0", o_timeout); end
    scan_frame(8'h4F, 8'h5B, 8'h39);
    n_cmp++; if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL tout_resume_f2 got %b want 0", o_frame_valid); end
    scan_frame(8'h4F, 8'h5B, 8'h39);
    n_cmp++; if (o_frame_valid !== 1'b1) begin n_bad++; $display("FAIL tout_resume_valid got %b want 1", o_frame_valid); end
    n_cmp++; if (o_digits !== 12'hC23) begin n_bad++; $display("FAIL tout_resume_digits got %h want C23", o_digits); end
    n_cmp++; if (stb_cnt !== base + 1) begin n_bad++; $display("FAIL tout_resume_stb got %0d want %0d", stb_cnt, base + 1); end
  endtask

  task automatic test_reset_mid;
    int base;
    drive(3'b001, 8'h07, DW);
    drive(3'b010, 8'h77, DW);
    drive(3'b100, 8'h71, 5);
    base = stb_cnt;
    i_rst = 1'b1;
    step(1);
    $display("reset mid-settle -> digits=%h valid=%b err=%b stb=%b", o_digits, o_frame_valid, o_seg_err, o_frame_stb);
    n_cmp++; if (o_digits !== 12'h000) begin n_bad++; $display("FAIL rmid_digits got %h want 000", o_digits); end
    n_cmp++; if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b want 0", o_frame_valid); end
    n_cmp++; if (o_seg_err !== 1'b0) begin n_bad++; $display("FAIL rmid_err got %b want 0", o_seg_err); end
    n_cmp++; if (o_frame_stb !== 1'b0) begin n_bad++; $display("FAIL rmid_stb got %b want 0", o_frame_stb); end
    i_rst = 1'b0;
    drive(3'b100, 8'h71, DW);
    drive(3'b001, 8'h07, DW);
    drive(3'b010, 8'h77, DW);
    for (int f = 0; f < 2; f++) begin
      drive(3'b100, 8'h71, DW);
      drive(3'b001, 8'h07, DW);
      drive(3'b010, 8'h77, DW);
      $display("rescan frame %0d -> digits=%h valid=%b stbs=%0d", f + 2, o_digits, o_frame_valid, stb_cnt);
      if (f == 0) begin
        n_cmp++; if (o_frame_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_f2_valid got %b want 0", o_frame_valid); end
      end
    end
    n_cmp++; if (o_frame_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_valid_f3 got %b want 1", o_frame_valid); end
    n_cmp++; if (o_digits !== 12'hFA7) begin n_bad++; $display("FAIL rmid_digits_f3 got %h want FA7", o_digits); end
    n_cmp++; if (stb_cnt !== base + 1) begin n_bad++; $display("FAIL rmid_stb_f3 got %0d want %0d", stb_cnt, base + 1); end
  endtask

  task automatic test_dp;
    int base;
    int exp_stb;
    logic [2:0] exp_dp;
    base = stb_cnt;
`ifdef SCAN_DP_CAPTURE_EN
    exp_dp  = 3'b010;
    exp_stb = base + 1;
`else
    exp_dp  = 3'b000;
    exp_stb = base;
`endif
    for (int f = 0; f < 3; f++) scan_frame(8'h07, 8'hF7, 8'h71);
    n_cmp++; if (o_dp !== exp_dp) begin n_bad++; $display("FAIL dp_out got %b want %b", o_dp, exp_dp); end
    n_cmp++; if (o_digits !== 12'hFA7) begin n_bad++; $display("FAIL dp_digits got %h want FA7", o_digits); end
    n_cmp++; if (stb_cnt !== exp_stb) begin n_bad++; $display("FAIL dp_stb got %0d want %0d", stb_cnt, exp_stb); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_seg_err;
    test_change_back;
    test_timeout;
    test_reset_mid;
    test_dp;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
